// File: rtl/qspi_fifo.sv
// rtl/qspi_fifo.sv - Shared QSPI TX/RX FIFO with thresholds, sticky errors and flush
// Define QSPI_FIFO_FWFT_EN to select first-word-fall-through reads.
module qspi_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LVL_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  input  logic [LVL_W-1:0] af_thresh_i,
  input  logic [LVL_W-1:0] ae_thresh_i,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             err_clr_i
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_set;
  logic             unf_set;
  logic             ovf_q;
  logic             unf_q;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o         = (level == LVL_FULL);
  assign empty_o        = (level == '0);
  assign level_o        = level;
  assign almost_full_o  = (level >= af_thresh_i);
  assign almost_empty_o = (level <= ae_thresh_i);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

  // A flush cycle swallows both requests and cannot raise an error.
  assign wr_acc  = wr_en_i && !full_o && !flush_i;
  assign rd_acc  = rd_en_i && !empty_o && !flush_i;
  assign ovf_set = wr_en_i && full_o && !flush_i;
  assign unf_set = rd_en_i && empty_o && !flush_i;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (wr_acc && !rd_acc) begin
        level <= level + LVL_W'(1);
      end else if (rd_acc && !wr_acc) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set || (ovf_q && !err_clr_i);
      unf_q <= unf_set || (unf_q && !err_clr_i);
    end
  end

`ifdef QSPI_FIFO_FWFT_EN
  assign rd_data_o  = empty_o ? '0 : mem[rd_ptr];
  assign rd_valid_o = !empty_o;
`else
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= mem[rd_ptr];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_qspi_fifo.sv
// tb/tb_qspi_fifo.sv - Self-checking bench for qspi_fifo at DEPTH 4 and DEPTH 5
// Both instances see the same stimulus; a queue model checks them every cycle.
module tb_qspi_fifo;
  localparam int W = 32;
  localparam int L = 8;
  localparam int DEP [2] = '{4, 5};

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          ec = 1'b0;
  logic [W-1:0]  wd = '0;
  logic [L-1:0]  af = 8'd3;
  logic [L-1:0]  ae = 8'd1;

  logic [W-1:0]  rdata [2];
  logic          rvalid [2];
  logic          full [2];
  logic          empty [2];
  logic [L-1:0]  lvl [2];
  logic          afo [2];
  logic          aeo [2];
  logic          ovf [2];
  logic          unf [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qspi_fifo #(.WIDTH(W), .DEPTH(4), .LVL_W(L)) u_d4 (
    .clk(clk), .resetn(resetn), .flush_i(flush), .wr_en_i(wr), .wr_data_i(wd),
    .rd_en_i(rd), .rd_data_o(rdata[0]), .rd_valid_o(rvalid[0]), .full_o(full[0]),
    .empty_o(empty[0]), .level_o(lvl[0]), .af_thresh_i(af), .ae_thresh_i(ae),
    .almost_full_o(afo[0]), .almost_empty_o(aeo[0]), .overflow_o(ovf[0]),
    .underflow_o(unf[0]), .err_clr_i(ec)
  );

  qspi_fifo #(.WIDTH(W), .DEPTH(5), .LVL_W(L)) u_d5 (
    .clk(clk), .resetn(resetn), .flush_i(flush), .wr_en_i(wr), .wr_data_i(wd),
    .rd_en_i(rd), .rd_data_o(rdata[1]), .rd_valid_o(rvalid[1]), .full_o(full[1]),
    .empty_o(empty[1]), .level_o(lvl[1]), .af_thresh_i(af), .ae_thresh_i(ae),
    .almost_full_o(afo[1]), .almost_empty_o(aeo[1]), .overflow_o(ovf[1]),
    .underflow_o(unf[1]), .err_clr_i(ec)
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: a queue per instance plus sticky flags and the last popped word.
  logic [W-1:0] mq [2][$];
  logic         m_ovf [2];
  logic         m_unf [2];
  logic [W-1:0] m_rdata [2];
  logic         m_rvalid [2];
  logic         m_full;
  logic         m_empty;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
        m_rdata[i] = '0;
        m_rvalid[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (flush) begin
          mq[i].delete();
          m_rvalid[i] = 1'b0;
          if (ec) begin
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
          end
        end else begin
          m_full = (mq[i].size() == DEP[i]);
          m_empty = (mq[i].size() == 0);
          m_ovf[i] = (wr && m_full) || (m_ovf[i] && !ec);
          m_unf[i] = (rd && m_empty) || (m_unf[i] && !ec);
          m_rvalid[i] = rd && !m_empty;
          if (rd && !m_empty) m_rdata[i] = mq[i].pop_front();
          if (wr && !m_full) mq[i].push_back(wd);
        end
      end
    end
  end

  int           c_n;
  logic [W-1:0] c_head;

  always @(negedge clk) begin
    if (resetn) begin
      for (int i = 0; i < 2; i++) begin
        c_n = mq[i].size();
        c_head = '0;
        if (c_n != 0) c_head = mq[i][0];
        chk("level", i, 32'(lvl[i]), 32'(c_n));
        chk("full", i, 32'(full[i]), 32'(c_n == DEP[i]));
        chk("empty", i, 32'(empty[i]), 32'(c_n == 0));
        chk("almost_full", i, 32'(afo[i]), 32'(c_n >= int'(af)));
        chk("almost_empty", i, 32'(aeo[i]), 32'(c_n <= int'(ae)));
        chk("overflow", i, 32'(ovf[i]), 32'(m_ovf[i]));
        chk("underflow", i, 32'(unf[i]), 32'(m_unf[i]));
`ifdef QSPI_FIFO_FWFT_EN
        chk("rd_valid", i, 32'(rvalid[i]), 32'(c_n != 0));
        chk("rd_data", i, rdata[i], c_head);
`else
        chk("rd_valid", i, 32'(rvalid[i]), 32'(m_rvalid[i]));
        chk("rd_data", i, rdata[i], m_rdata[i]);
`endif
      end
    end
  end

  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic f, input logic c);
    wr = w; wd = d; rd = r; flush = f; ec = c;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; ec = 1'b0;
  endtask

  // Pop (optionally with a write) and check the word that leaves instance i.
  task automatic pop_chk(input int i, input logic [W-1:0] exp, input logic w, input logic [W-1:0] d);
`ifdef QSPI_FIFO_FWFT_EN
    chk("pop_data", i, rdata[i], exp);
    step(w, d, 1'b1, 1'b0, 1'b0);
`else
    step(w, d, 1'b1, 1'b0, 1'b0);
    chk("pop_data", i, rdata[i], exp);
    chk("pop_valid", i, 32'(rvalid[i]), 32'd1);
`endif
  endtask

  logic ae_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic af_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 0, 32'(lvl[0]), 32'd0);
    chk("rst_empty", 0, 32'(empty[0]), 32'd1);
    chk("rst_full", 0, 32'(full[0]), 32'd0);
    chk("rst_valid", 0, 32'(rvalid[0]), 32'd0);
    chk("rst_data", 0, rdata[0], 32'd0);
    chk("rst_ovf", 0, 32'(ovf[0]), 32'd0);
    resetn = 1'b1;
    step(0, 0, 0, 0, 0);

    // Fill and drain DEPTH 4.
    for (int k = 0; k < 4; k++) step(1, W'(k), 0, 0, 0);
    chk("t1_full", 0, 32'(full[0]), 32'd1);
    chk("t1_level", 0, 32'(lvl[0]), 32'd4);
    chk("t1_empty", 0, 32'(empty[0]), 32'd0);
    chk("t1_full5", 1, 32'(full[1]), 32'd0);
    for (int k = 0; k < 4; k++) pop_chk(0, W'(k), 1'b0, '0);
    step(0, 0, 0, 0, 0);
    chk("t1_pulse_end", 0, 32'(rvalid[0]), 32'(0));
    chk("t1_empty_end", 0, 32'(empty[0]), 32'd1);

    // DEPTH 5 pointer wrap: write 5, read 3, write 3, read 5.
    for (int k = 0; k < 5; k++) step(1, W'(k), 0, 0, 0);
    chk("t2_full5", 1, 32'(full[1]), 32'd1);
    for (int k = 0; k < 3; k++) pop_chk(1, W'(k), 1'b0, '0);
    for (int k = 5; k < 8; k++) step(1, W'(k), 0, 0, 0);
    chk("t2_level5", 1, 32'(lvl[1]), 32'd5);
    for (int k = 3; k < 8; k++) pop_chk(1, W'(k), 1'b0, '0);
    chk("t2_level_end", 1, 32'(lvl[1]), 32'd0);
    step(0, 0, 0, 0, 1);
    chk("t2_clr_ovf", 0, 32'(ovf[0]), 32'd0);
    chk("t2_clr_unf", 0, 32'(unf[0]), 32'd0);

    // Overflow, full boundary, underflow, clear priority.
    for (int k = 10; k < 14; k++) step(1, W'(k), 0, 0, 0);
    step(1, 99, 0, 0, 0);
    chk("t3_ovf", 0, 32'(ovf[0]), 32'd1);
    chk("t3_ovf_level", 0, 32'(lvl[0]), 32'd4);
    chk("t3_ovf5", 1, 32'(ovf[1]), 32'd0);
    pop_chk(0, 10, 1'b1, 20);
    chk("t3_full_rw_level", 0, 32'(lvl[0]), 32'd3);
    for (int k = 11; k < 14; k++) pop_chk(0, W'(k), 1'b0, '0);
    step(0, 0, 1, 0, 0);
    chk("t3_unf", 0, 32'(unf[0]), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("t3_clr_ovf", 0, 32'(ovf[0]), 32'd0);
    chk("t3_clr_unf", 0, 32'(unf[0]), 32'd0);
    step(1, 30, 1, 0, 0);
    chk("t3_empty_rw_level", 0, 32'(lvl[0]), 32'd1);
    chk("t3_empty_rw_unf", 0, 32'(unf[0]), 32'd1);
    step(0, 0, 0, 0, 1);
    for (int k = 31; k < 34; k++) step(1, W'(k), 0, 0, 0);
    step(1, 40, 0, 0, 1);
    chk("t3_set_beats_clr", 0, 32'(ovf[0]), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("t3_clr_again", 0, 32'(ovf[0]), 32'd0);
    step(0, 0, 0, 1, 1);
    chk("t3_flush_level", 0, 32'(lvl[0]), 32'd0);
    step(0, 0, 1, 1, 0);
    chk("t3_flush_no_unf", 0, 32'(unf[0]), 32'd0);

    // Threshold sweep.
    for (int k = 0; k < 5; k++) begin
      chk("t4_level", 0, 32'(lvl[0]), 32'(k));
      chk("t4_ae", 0, 32'(aeo[0]), 32'(ae_tab[k]));
      chk("t4_af", 0, 32'(afo[0]), 32'(af_tab[k]));
      if (k < 4) step(1, W'(50 + k), 0, 0, 0);
    end

    // Flush with a coincident write.
    pop_chk(0, 50, 1'b0, '0);
    chk("t5_level3", 0, 32'(lvl[0]), 32'd3);
    step(1, 77, 0, 1, 0);
    chk("t5_level", 0, 32'(lvl[0]), 32'd0);
    chk("t5_empty", 0, 32'(empty[0]), 32'd1);
    chk("t5_ovf", 0, 32'(ovf[0]), 32'd0);
    chk("t5_valid", 0, 32'(rvalid[0]), 32'd0);
`ifndef QSPI_FIFO_FWFT_EN
    chk("t5_data_held", 0, rdata[0], 32'd50);
`endif

    // Threshold extremes.
    af = 8'd0; ae = 8'd4;
    step(0, 0, 0, 0, 0);
    chk("t4_af_zero", 0, 32'(afo[0]), 32'd1);
    for (int k = 0; k < 4; k++) step(1, W'(60 + k), 0, 0, 0);
    chk("t4_ae_depth", 0, 32'(aeo[0]), 32'd1);
    af = 8'd3; ae = 8'd1;
    step(0, 0, 0, 1, 1);

`ifdef QSPI_FIFO_FWFT_EN
    step(1, 32'hA5, 0, 0, 0);
    chk("t6_valid", 0, 32'(rvalid[0]), 32'd1);
    chk("t6_data", 0, rdata[0], 32'hA5);
    step(0, 0, 1, 0, 0);
    chk("t6_empty", 0, 32'(empty[0]), 32'd1);
    chk("t6_valid_low", 0, 32'(rvalid[0]), 32'd0);
`endif

    // Asynchronous reset in the middle of traffic.
    step(1, 88, 0, 0, 0);
    step(1, 89, 0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_level", 0, 32'(lvl[0]), 32'd0);
    chk("arst_empty", 0, 32'(empty[0]), 32'd1);
    chk("arst_level5", 1, 32'(lvl[1]), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    chk("arst_after_write", 0, 32'(lvl[0]), 32'd1);
    step(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
